// File: rtl/rx_lane_mux.sv
// Registered N-lane selector/serializer: captures one multi-lane word and emits
// either a single addressed lane (direct) or lanes 0..sel in order (sweep).
module rx_lane_mux #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int SW    = 3
) (
  input  logic                rxclk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [SW-1:0]       in_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [SW-1:0]       out_lane,
  output logic                out_last
);

  localparam logic [SW:0]   LANES_W   = (SW+1)'(LANES);
  localparam logic [SW-1:0] LAST_LANE = SW'(LANES - 1);

  logic [LANES*DW-1:0] data_r;
  logic [SW-1:0]       sel_r;
  logic [SW-1:0]       cnt_r;
  logic                mode_r;
  logic                full_r;

  logic [SW-1:0] sel_clamp_s;
  logic [DW-1:0] lane_s;
  logic [DW-1:0] lanes_s [2**SW];
  logic          last_s;
  logic          accept_s;
  logic          beat_s;

  // Lane view padded to a power of two so cnt_r always indexes a defined entry.
  for (genvar k = 0; k < 2**SW; k++) begin : g_lanes
    if (k < LANES) begin : g_real
      assign lanes_s[k] = data_r[k*DW +: DW];
    end else begin : g_pad
      assign lanes_s[k] = '0;
    end
  end

  // Clamp out-of-range select values to the highest lane at capture.
  always_comb begin
    sel_clamp_s = in_sel;
    if ({1'b0, in_sel} >= LANES_W) begin
      sel_clamp_s = LAST_LANE;
    end else begin
      sel_clamp_s = in_sel;
    end
  end

  assign lane_s    = lanes_s[cnt_r];
  assign last_s    = (mode_r == 1'b0) || (cnt_r == sel_r);
  assign out_valid = full_r && en;
  assign out_data  = out_valid ? lane_s : {DW{1'b0}};
  assign out_lane  = cnt_r;
  assign out_last  = out_valid && last_s;
  assign beat_s    = out_valid && out_ready;
  // Ready on the last-beat cycle lets the next word load without a bubble.
  assign in_ready  = en && !reset && (!full_r || (beat_s && last_s));
  assign accept_s  = in_valid && in_ready;

  // Holding register, lane counter and occupancy flag.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      data_r <= '0;
      sel_r  <= '0;
      cnt_r  <= '0;
      mode_r <= 1'b0;
      full_r <= 1'b0;
    end else if (accept_s) begin
      data_r <= in_data;
      sel_r  <= sel_clamp_s;
      mode_r <= mode;
      cnt_r  <= mode ? {SW{1'b0}} : sel_clamp_s;
      full_r <= 1'b1;
    end else if (beat_s) begin
      if (last_s) begin
        full_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_lane_mux.sv
// Self-checking bench for rx_lane_mux: directed scenarios then random traffic,
// compared against a queue of expected beats built from each accepted word.
module tb_rx_lane_mux;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int SW    = 3;

  logic                rxclk = 1'b0;
  logic                reset;
  logic                en;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic [SW-1:0]       in_sel;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [SW-1:0]       out_lane;
  logic                out_last;

  rx_lane_mux #(.LANES(LANES), .DW(DW), .SW(SW)) dut (
    .rxclk(rxclk), .reset(reset), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last)
  );

  always #5 rxclk = ~rxclk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] lane;
    logic          last;
  } beat_t;

  beat_t         q[$];
  logic [SW-1:0] last_lane;
  int            compared   = 0;
  int            mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [LANES*DW-1:0] d, input logic [SW-1:0] sel, input logic m);
    int    s;
    beat_t b;
    s = (int'(sel) >= LANES) ? LANES - 1 : int'(sel);
    if (!m) begin
      b.d = d[s*DW +: DW]; b.lane = SW'(s); b.last = 1'b1;
      q.push_back(b);
    end else begin
      for (int i = 0; i <= s; i++) begin
        b.d = d[i*DW +: DW]; b.lane = SW'(i); b.last = (i == s);
        q.push_back(b);
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_lane = '0;
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic step();
    logic ev, er, acc, bt;
    logic [SW-1:0] el;
    @(negedge rxclk);
    ev = en && !reset && (q.size() > 0);
    er = en && !reset && ((q.size() == 0) || (out_ready && q.size() == 1));
    el = (q.size() > 0) ? q[0].lane : last_lane;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data), ev ? 64'(q[0].d) : 64'd0);
    chk("out_last", 64'(out_last), ev ? 64'(q[0].last) : 64'd0);
    chk("out_lane", 64'(out_lane), 64'(el));
    chk("in_ready", 64'(in_ready), 64'(er));
    acc = in_valid && er;
    bt  = ev && out_ready;
    @(posedge rxclk);
    if (!reset) begin
      if (bt) begin
        last_lane = q[0].lane;
        void'(q.pop_front());
      end
      if (acc) push_word(in_data, in_sel, mode);
    end
    #1;
  endtask

  task automatic send(input logic m, input logic [SW-1:0] s);
    in_valid = 1'b1; mode = m; in_sel = s;
    step();
    in_valid = 1'b0;
  endtask

  localparam logic [63:0] W = 64'h8877665544332211;

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = W; in_sel = '0; out_ready = 1'b1;
    model_reset();
    #1;
    repeat (2) step();
    reset = 1'b0; en = 1'b1;

    // Direct word, lane 5 -> 0x66.
    send(1'b0, 3'd5);
    repeat (2) step();

    // Full sweep of all eight lanes.
    send(1'b1, 3'd7);
    repeat (9) step();

    // Back-pressure on beat 2 of a 4-beat sweep.
    send(1'b1, 3'd3);
    repeat (2) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Enable gap in the middle of a sweep.
    send(1'b1, 3'd7);
    repeat (3) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (7) step();

    // Back-to-back direct words with no bubble.
    in_valid = 1'b1; mode = 1'b0;
    in_sel = 3'd0; step();
    in_sel = 3'd7; step();
    in_sel = 3'd3; step();
    in_valid = 1'b0;
    repeat (2) step();

    // Sweep with sel=0 is a single last beat on lane 0.
    send(1'b1, 3'd0);
    repeat (2) step();

    // Asynchronous reset in the middle of a sweep.
    send(1'b1, 3'd7);
    repeat (3) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b0;
    send(1'b1, 3'd2);
    repeat (4) step();
    send(1'b0, 3'd6);
    repeat (2) step();

    // Randomized traffic, including mid-word changes of mode/sel and resets.
    for (int n = 0; n < 600; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      mode      = 1'($urandom_range(0, 1));
      in_sel    = SW'($urandom_range(0, LANES - 1));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
